// File: rtl/sap_alu.sv
`default_nettype none
// ============================================================================
// Module   : sap_alu
// Purpose  : Registered 16-bit arithmetic/logic unit for the SAP datapath.
//            The unit computes a 17-bit result from two 16-bit operands and a
//            4-bit opcode. res[16] carries the carry, borrow or shift-out bit.
//            The result and two flags are captured on the rising clock edge:
//            one cycle of latency and one operation per cycle.
//
// Ports    : clk   in   1   rising-edge clock
//            rst   in   1   synchronous active-high reset
//            a     in  16   operand A
//            b     in  16   operand B (single-operand ops ignore it)
//            op    in   4   opcode
//            res   out 17   registered result, res[16] = carry/borrow/shift-out
//            flag  out  2   registered flags, [1] = carry (res[16]),
//                           [0] = zero (res[15:0] == 0)
//
// Config   : ALU_EXT_OPS_EN  when defined, opcodes 8-15 (INC, DEC, PASSA,
//                            PASSB, ASR, NAND, NOR, XNOR) are implemented.
//                            When undefined, those opcodes produce a zero
//                            result, so the flags read 2'b01.
//
// Revision : 1.0  initial release
// ============================================================================
module sap_alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [3:0]  op,
    output logic [16:0] res,
    output logic [1:0]  flag
);

    // ------------------------------------------------------------------------
    // Opcode map
    // ------------------------------------------------------------------------
    localparam logic [3:0] c_OP_ADD   = 4'd0;
    localparam logic [3:0] c_OP_SUB   = 4'd1;
    localparam logic [3:0] c_OP_AND   = 4'd2;
    localparam logic [3:0] c_OP_OR    = 4'd3;
    localparam logic [3:0] c_OP_XOR   = 4'd4;
    localparam logic [3:0] c_OP_NOT   = 4'd5;
    localparam logic [3:0] c_OP_SHL   = 4'd6;
    localparam logic [3:0] c_OP_SHR   = 4'd7;
`ifdef ALU_EXT_OPS_EN
    localparam logic [3:0] c_OP_INC   = 4'd8;
    localparam logic [3:0] c_OP_DEC   = 4'd9;
    localparam logic [3:0] c_OP_PASSA = 4'd10;
    localparam logic [3:0] c_OP_PASSB = 4'd11;
    localparam logic [3:0] c_OP_ASR   = 4'd12;
    localparam logic [3:0] c_OP_NAND  = 4'd13;
    localparam logic [3:0] c_OP_NOR   = 4'd14;
    localparam logic [3:0] c_OP_XNOR  = 4'd15;
`endif

    // ------------------------------------------------------------------------
    // Zero-extended operands. All arithmetic is done at 17 bits. For
    // subtraction and decrement, the wrap-around into bit 16 is exactly the
    // unsigned borrow.
    // ------------------------------------------------------------------------
    logic [16:0] w_a_ext;
    logic [16:0] w_b_ext;

    assign w_a_ext = {1'b0, a};
    assign w_b_ext = {1'b0, b};

    // ------------------------------------------------------------------------
    // Result selection
    // ------------------------------------------------------------------------
    logic [16:0] w_res;

    always_comb begin
        w_res = 17'h0_0000;
        case (op)
            c_OP_ADD:   w_res = w_a_ext + w_b_ext;
            c_OP_SUB:   w_res = w_a_ext - w_b_ext;
            c_OP_AND:   w_res = {1'b0, a & b};
            c_OP_OR:    w_res = {1'b0, a | b};
            c_OP_XOR:   w_res = {1'b0, a ^ b};
            c_OP_NOT:   w_res = {1'b0, ~a};
            c_OP_SHL:   w_res = {a, 1'b0};
            c_OP_SHR:   w_res = {a[0], 1'b0, a[15:1]};
`ifdef ALU_EXT_OPS_EN
            c_OP_INC:   w_res = w_a_ext + 17'd1;
            c_OP_DEC:   w_res = w_a_ext - 17'd1;
            c_OP_PASSA: w_res = w_a_ext;
            c_OP_PASSB: w_res = w_b_ext;
            c_OP_ASR:   w_res = {a[0], a[15], a[15:1]};
            c_OP_NAND:  w_res = {1'b0, ~(a & b)};
            c_OP_NOR:   w_res = {1'b0, ~(a | b)};
            c_OP_XNOR:  w_res = {1'b0, ~(a ^ b)};
`endif
            // The upper half of the opcode space is unimplemented in the base
            // build and yields a zero result.
            default:    w_res = 17'h0_0000;
        endcase
    end

    // ------------------------------------------------------------------------
    // Flags are derived only from the result of this cycle. The flags are not
    // sticky, and there is no carry-in.
    // ------------------------------------------------------------------------
    logic [1:0] w_flag;

    assign w_flag = {w_res[16], (w_res[15:0] == 16'h0000)};

    // ------------------------------------------------------------------------
    // Output register stage. During reset the zero flag is forced low even
    // though the result is zero.
    // ------------------------------------------------------------------------
    logic [16:0] r_res;
    logic [1:0]  r_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res  <= 17'h0_0000;
            r_flag <= 2'b00;
        end else begin
            r_res  <= w_res;
            r_flag <= w_flag;
        end
    end

    assign res  = r_res;
    assign flag = r_flag;

endmodule
`default_nettype wire

// File: tb/tb_sap_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_sap_alu
// Purpose  : Self-checking bench for sap_alu. A behavioural model computes
//            each expected result from the opcode rules using plain integer
//            arithmetic. Stimulus is directed and $urandom-driven.
// Revision : 1.0  initial release
// ============================================================================
module tb_sap_alu;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic [16:0] res;
    logic [1:0]  flag;

    int vectors;
    int miscompares;

    sap_alu dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .op   (op),
        .res  (res),
        .flag (flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model. It uses integer arithmetic on unsigned values.
    // Results modulo 2^17 are formed by adding 2^17 before the subtraction.
    // ------------------------------------------------------------------------
    function automatic logic [16:0] model_res(input int unsigned o,
                                              input int unsigned x,
                                              input int unsigned y);
        int unsigned r;
        case (o)
            0:  r = x + y;
            1:  r = (x + 32'h2_0000 - y) % 32'h2_0000;
            2:  r = x & y;
            3:  r = x | y;
            4:  r = x ^ y;
            5:  r = x ^ 32'hFFFF;
            6:  r = x * 2;
            7:  r = x / 2 + (x % 2) * 32'h1_0000;
`ifdef ALU_EXT_OPS_EN
            8:  r = x + 1;
            9:  r = (x + 32'h1_FFFF) % 32'h2_0000;
            10: r = x;
            11: r = y;
            12: r = x / 2 + ((x >= 32'h8000) ? 32'h8000 : 0) + (x % 2) * 32'h1_0000;
            13: r = (x & y) ^ 32'hFFFF;
            14: r = (x | y) ^ 32'hFFFF;
            15: r = (x ^ y) ^ 32'hFFFF;
`endif
            default: r = 0;
        endcase
        return r[16:0];
    endfunction

    function automatic logic [1:0] model_flag(input logic [16:0] r);
        return {r[16], (r % 17'h1_0000) == 17'h0};
    endfunction

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; a = 16'h1234; b = 16'h0001; op = 4'd0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (res !== 17'h0_0000 || flag !== 2'b00) begin
                miscompares++;
                $display("FAIL reset_edge%0d: got res=%05h flag=%b, want res=00000 flag=00", i, res, flag);
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (res !== 17'h0_1235 || flag !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_release: got res=%05h flag=%b, want res=01235 flag=00", res, flag);
        end
    endtask

    // ------------------------------------------------------------------------
    // Directed corner cases with hand-derived expected values.
    // ------------------------------------------------------------------------
    task automatic test_directed();
        logic [3:0]  t_op  [11];
        logic [15:0] t_a   [11];
        logic [15:0] t_b   [11];
        logic [16:0] t_res [11];
        logic [1:0]  t_flg [11];
        t_op[0]  = 0;  t_a[0]  = 16'hFFFD; t_b[0]  = 16'h0005; t_res[0]  = 17'h1_0002; t_flg[0]  = 2'b10;
        t_op[1]  = 0;  t_a[1]  = 16'hFFFF; t_b[1]  = 16'h0001; t_res[1]  = 17'h1_0000; t_flg[1]  = 2'b11;
        t_op[2]  = 1;  t_a[2]  = 16'h0003; t_b[2]  = 16'h0005; t_res[2]  = 17'h1_FFFE; t_flg[2]  = 2'b10;
        t_op[3]  = 1;  t_a[3]  = 16'h0005; t_b[3]  = 16'h0005; t_res[3]  = 17'h0_0000; t_flg[3]  = 2'b01;
        t_op[4]  = 4;  t_a[4]  = 16'h00FF; t_b[4]  = 16'h00FF; t_res[4]  = 17'h0_0000; t_flg[4]  = 2'b01;
        t_op[5]  = 5;  t_a[5]  = 16'h0000; t_b[5]  = 16'hABCD; t_res[5]  = 17'h0_FFFF; t_flg[5]  = 2'b00;
        t_op[6]  = 6;  t_a[6]  = 16'h8001; t_b[6]  = 16'h1111; t_res[6]  = 17'h1_0002; t_flg[6]  = 2'b10;
        t_op[7]  = 7;  t_a[7]  = 16'h0003; t_b[7]  = 16'h2222; t_res[7]  = 17'h1_0001; t_flg[7]  = 2'b10;
        t_op[8]  = 2;  t_a[8]  = 16'hF0F0; t_b[8]  = 16'h3C3C; t_res[8]  = 17'h0_3030; t_flg[8]  = 2'b00;
        t_op[9]  = 3;  t_a[9]  = 16'h0000; t_b[9]  = 16'h0000; t_res[9]  = 17'h0_0000; t_flg[9]  = 2'b01;
`ifdef ALU_EXT_OPS_EN
        t_op[10] = 12; t_a[10] = 16'h8003; t_b[10] = 16'h0000; t_res[10] = 17'h1_C001; t_flg[10] = 2'b10;
`else
        t_op[10] = 12; t_a[10] = 16'h8003; t_b[10] = 16'h0000; t_res[10] = 17'h0_0000; t_flg[10] = 2'b01;
`endif
        for (int i = 0; i < 11; i++) begin
            op = t_op[i]; a = t_a[i]; b = t_b[i];
            @(posedge clk); #1;
            vectors++;
            if (res !== t_res[i] || flag !== t_flg[i]) begin
                miscompares++;
                $display("FAIL directed%0d op=%0d a=%04h b=%04h: got res=%05h flag=%b, want res=%05h flag=%b",
                         i, t_op[i], t_a[i], t_b[i], res, flag, t_res[i], t_flg[i]);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    // Cover every opcode with boundary operands: 0, 1, 0x7FFF, 0x8000, 0xFFFF.
    // ------------------------------------------------------------------------
    task automatic test_corners();
        logic [15:0] vals [5];
        logic [16:0] er;
        logic [1:0]  ef;
        vals[0] = 16'h0000; vals[1] = 16'h0001; vals[2] = 16'h7FFF;
        vals[3] = 16'h8000; vals[4] = 16'hFFFF;
        for (int o = 0; o < 16; o++) begin
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 5; j += 2) begin
                    op = o[3:0]; a = vals[i]; b = vals[j];
                    er = model_res(o, a, b);
                    ef = model_flag(er);
                    @(posedge clk); #1;
                    vectors++;
                    if (res !== er || flag !== ef) begin
                        miscompares++;
                        $display("FAIL corner op=%0d a=%04h b=%04h: got res=%05h flag=%b, want res=%05h flag=%b",
                                 o, a, b, res, flag, er, ef);
                    end
                end
            end
        end
    endtask

    // ------------------------------------------------------------------------
    // Back-to-back random operations. A new operation is applied every cycle,
    // and each result is checked against the inputs present at its edge.
    // ------------------------------------------------------------------------
    task automatic test_back_to_back();
        logic [16:0] er;
        logic [1:0]  ef;
        for (int n = 0; n < 400; n++) begin
            op = 4'($urandom_range(0, 15));
            a  = 16'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? a : 16'($urandom);
            er = model_res(op, a, b);
            ef = model_flag(er);
            @(posedge clk); #1;
            vectors++;
            if (res !== er || flag !== ef) begin
                miscompares++;
                $display("FAIL random op=%0d a=%04h b=%04h: got res=%05h flag=%b, want res=%05h flag=%b",
                         op, a, b, res, flag, er, ef);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    // Inputs that change between edges must not affect the outputs.
    // ------------------------------------------------------------------------
    task automatic test_between_edges();
        logic [16:0] er;
        logic [1:0]  ef;
        for (int n = 0; n < 20; n++) begin
            op = 4'($urandom_range(0, 7)); a = 16'($urandom); b = 16'($urandom);
            er = model_res(op, a, b);
            ef = model_flag(er);
            @(posedge clk); #1;
            op = 4'($urandom_range(0, 15)); a = 16'($urandom); b = 16'($urandom);
            #2;
            vectors++;
            if (res !== er || flag !== ef) begin
                miscompares++;
                $display("FAIL hold: got res=%05h flag=%b, want res=%05h flag=%b", res, flag, er, ef);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    // A reset in the middle of a stream discards the in-flight result. The
    // next result then follows directly from the next set of inputs.
    // ------------------------------------------------------------------------
    task automatic test_midstream_reset();
        logic [16:0] er;
        logic [1:0]  ef;
        for (int n = 0; n < 5; n++) begin
            op = 4'd0; a = 16'hFFFF; b = 16'($urandom_range(1, 65535));
            @(posedge clk); #1;
            rst = 1'b1; op = 4'd1; a = 16'h0000; b = 16'h0001;
            @(posedge clk); #1;
            vectors++;
            if (res !== 17'h0_0000 || flag !== 2'b00) begin
                miscompares++;
                $display("FAIL midreset: got res=%05h flag=%b, want res=00000 flag=00", res, flag);
            end
            rst = 1'b0; op = 4'($urandom_range(0, 15)); a = 16'($urandom); b = 16'($urandom);
            er = model_res(op, a, b);
            ef = model_flag(er);
            @(posedge clk); #1;
            vectors++;
            if (res !== er || flag !== ef) begin
                miscompares++;
                $display("FAIL after_midreset: got res=%05h flag=%b, want res=%05h flag=%b", res, flag, er, ef);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1; a = 16'h0; b = 16'h0; op = 4'h0;
        test_reset();
        test_directed();
        test_corners();
        test_back_to_back();
        test_between_edges();
        test_midstream_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
